ram_stream_fifo_ctrl: RTL and testbench
=======================================

RAM_STREAM_FIFO_CTRL -- requirements
Module: ram_stream_fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 10, RAM address bits.
REQ-003 SHALL have parameter WORDS, default 1024, RAM capacity; WORDS == 2**DEPTH.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: s_valid  in  1  push request.
REQ-007 SHALL have ports: s_ready  out  1  push accepted when s_valid&&s_ready.
REQ-008 SHALL have ports: s_data  in  WIDTH  push word.
REQ-009 SHALL have ports: m_valid  out  1  output word present.
REQ-010 SHALL have ports: m_ready  in  1  pop when m_valid&&m_ready.
REQ-011 SHALL have ports: m_data  out  WIDTH  output word, held stable while m_valid&&!m_ready.
REQ-012 SHALL have ports: count  out  32  words held (RAM + in-flight + output buffer).
REQ-013 SHALL have ports: ram_waddress  out  32  RAM write address, zero-extended.
REQ-014 SHALL have ports: ram_din  out  WIDTH  RAM write data.
REQ-015 SHALL have ports: ram_we  out  1  RAM write enable.
REQ-016 SHALL have ports: ram_raddress  out  32  RAM read address, zero-extended.
REQ-017 SHALL have ports: ram_dout  in  WIDTH  RAM read data, valid one cycle after ram_raddress is sampled.

Function
REQ-018 SHALL be a first-word-fall-through FIFO using the external RAM as storage plus a 2-entry output buffer; total capacity WORDS+2.
REQ-019 SHALL drive s_ready = (ram_count != WORDS), ram_count = registered count of words written to RAM but not yet read.
REQ-020 SHALL, on push, assert ram_we combinationally with ram_din=s_data, ram_waddress=wptr; wptr increments after the edge, wrapping WORDS-1 -> 0.
REQ-021 SHALL issue a RAM read (present rptr on ram_raddress, increment rptr with wrap) in a cycle only when ram_count>0 and buffered+inflight-pop < 2, where pop = m_valid&&m_ready in that cycle.
REQ-022 SHALL capture ram_dout into the output buffer at the end of the cycle after the read issue; inflight is 0 or 1.
REQ-023 SHALL never read an address being written in the same cycle (guaranteed by REQ-021 using registered ram_count).
REQ-024 SHALL sustain one push and one pop per cycle with no bubbles once the output buffer is primed.
REQ-025 SHALL present a word on m_valid 3 cycles after its push into an empty FIFO (push cycle N, m_valid high in N+3).
REQ-026 SHALL preserve strict FIFO order across pointer wrap-around.
REQ-027 SHALL handle simultaneous push and pop: count unchanged; simultaneous push and read issue: ram_count unchanged.
REQ-028 SHALL ignore s_data/ram_dout when not accepted/expected; m_data is don't-care when m_valid=0.
REQ-029 SHALL update count at every edge as count + push - pop, range 0..WORDS+2.

Reset
REQ-030 SHALL, while reset=0, force wptr=0, rptr=0, ram_count=0, inflight=0, output buffer empty, m_valid=0, count=0, ram_we=0.
REQ-031 SHALL discard all stored and in-flight words on reset assertion mid-operation; RAM contents are not cleared.
REQ-032 SHALL assert s_ready=1 from the first cycle after reset deasserts.

Structure
REQ-033 SHALL use no shared package; DEPTH/WORDS are module parameters, buffer depth 2 is a localparam.
REQ-034 SHALL place the 2-entry output buffer in sub-module stream_skid2 (WIDTH parameter, valid/ready both sides, async active-low reset).
REQ-035 SHALL not instantiate the RAM; the parent connects it via the ram_* ports.

Verification
REQ-036 SHALL test: reset, push 0xA5 at cycle 0, m_ready=1 -> m_valid at cycle 3 with m_data=0xA5, count 1 then 0.
REQ-037 SHALL test: WORDS=16, push 18 words, m_ready=0 -> s_ready=0 after word 18, count=18, ram_count=16.
REQ-038 SHALL test: continuous push/pop of 0..4095 with WORDS=16 -> output 0..4095 in order, one per cycle after priming, pointers wrap.
REQ-039 SHALL test: random s_valid/m_ready back-pressure, 10000 words -> scoreboard order match, m_data stable while stalled.
REQ-040 SHALL test: reset asserted with 5 words stored and a read in flight -> m_valid=0, count=0 immediately; next push 0x11 emerges first.

Source files
------------

// File: rtl/stream_skid2.sv
// Two-entry stream buffer with valid/ready on both sides; m_valid and m_data
// come straight from registers so the consumer sees no combinational path.
module stream_skid2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       level
);
   localparam int SLOTS = 2;

   logic [WIDTH-1:0] mem [SLOTS];
   logic             head_q;
   logic             tail_q;
   logic [1:0]       level_q;
   logic             push;
   logic             pop;

   assign s_ready = (level_q != 2'd2);
   assign m_valid = (level_q != 2'd0);
   assign m_data  = mem[head_q];
   assign level   = level_q;
   assign push    = s_valid && s_ready;
   assign pop     = m_valid && m_ready;

   // NOTE: the data slots are not reset; level_q alone decides which slots hold live words.
   always_ff @(posedge clk) begin
      if (push) mem[tail_q] <= s_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         level_q <= 2'd0;
      end else begin
         if (push) tail_q <= ~tail_q;
         if (pop)  head_q <= ~head_q;
         level_q <= level_q + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: rtl/ram_stream_fifo_ctrl.sv
// First-word-fall-through FIFO that keeps its bulk storage in an external
// synchronous RAM and prefetches into a two-entry output buffer.
module ram_stream_fifo_ctrl #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 10,
   parameter int WORDS = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [31:0]      count,
   output logic [31:0]      ram_waddress,
   output logic [WIDTH-1:0] ram_din,
   output logic             ram_we,
   output logic [31:0]      ram_raddress,
   input  logic [WIDTH-1:0] ram_dout
);
   localparam int             BUF_DEPTH = 2;
   localparam logic [DEPTH:0] RAM_FULL  = (DEPTH+1)'(WORDS);
   localparam logic [DEPTH:0] CNT_ONE   = (DEPTH+1)'(1);
   localparam logic [DEPTH-1:0] LAST_ADDR = DEPTH'(WORDS - 1);
   localparam logic [DEPTH-1:0] PTR_ONE   = DEPTH'(1);

   logic [DEPTH-1:0] wptr_q;
   logic [DEPTH-1:0] rptr_q;
   logic [DEPTH:0]   ram_count_q;
   logic             inflight_q;
   logic [31:0]      count_q;
   logic             push;
   logic             pop;
   logic             issue;
   logic             buf_room;
   logic             buf_ready;
   logic [1:0]       buf_level;

   // Writes are held off during reset so a request presented then cannot reach the RAM.
   assign s_ready      = reset && (ram_count_q != RAM_FULL);
   assign push         = s_valid && s_ready;
   assign pop          = m_valid && m_ready;
   assign ram_we       = push;
   assign ram_din      = s_data;
   assign ram_waddress = 32'(wptr_q);
   assign ram_raddress = 32'(rptr_q);
   assign count        = count_q;

   // Room for one more word once buffered + inflight - pop is below BUF_DEPTH.
   always_comb begin
      buf_room = 1'b0;
      if (inflight_q) buf_room = (buf_level == 2'd0) || (buf_level == 2'(BUF_DEPTH - 1) && pop);
      else            buf_room = buf_ready || pop;
   end

   // ram_count_q is registered, so a word written this cycle is never read this cycle.
   assign issue = (ram_count_q != '0) && buf_room;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         ram_count_q <= '0;
         inflight_q  <= 1'b0;
         count_q     <= '0;
      end else begin
         if (push)  wptr_q <= (wptr_q == LAST_ADDR) ? '0 : wptr_q + PTR_ONE;
         if (issue) rptr_q <= (rptr_q == LAST_ADDR) ? '0 : rptr_q + PTR_ONE;
         case ({push, issue})
            2'b10:   ram_count_q <= ram_count_q + CNT_ONE;
            2'b01:   ram_count_q <= ram_count_q - CNT_ONE;
            default: ram_count_q <= ram_count_q;
         endcase
         inflight_q <= issue;
         count_q    <= count_q + 32'(push) - 32'(pop);
      end
   end

   stream_skid2 #(.WIDTH(WIDTH)) u_out_buf (
      .clk     (clk),
      .reset   (reset),
      .s_valid (inflight_q),
      .s_ready (buf_ready),
      .s_data  (ram_dout),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .level   (buf_level)
   );
endmodule

// File: tb/tb_ram_stream_fifo_ctrl.sv
// Directed and randomised bench for ram_stream_fifo_ctrl with a 16-word RAM;
// a queue model predicts count, order, visibility latency and hold behaviour.
module tb_ram_stream_fifo_ctrl;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int WORDS = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic [31:0]      count;
   logic [31:0]      ram_waddress;
   logic [WIDTH-1:0] ram_din;
   logic             ram_we;
   logic [31:0]      ram_raddress;
   logic [WIDTH-1:0] ram_dout;

   always #5 clk = ~clk;

   ram_stream_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WORDS(WORDS)) dut (
      .clk          (clk),
      .reset        (reset),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .count        (count),
      .ram_waddress (ram_waddress),
      .ram_din      (ram_din),
      .ram_we       (ram_we),
      .ram_raddress (ram_raddress),
      .ram_dout     (ram_dout)
   );

   // Synchronous RAM: read data appears one cycle after the address is sampled.
   logic [WIDTH-1:0] ram [WORDS];
   always @(posedge clk) begin
      if (ram_we) ram[ram_waddress % WORDS] <= ram_din;
      ram_dout <= ram[ram_raddress % WORDS];
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: every word held, with the cycle it was pushed in.
   logic [WIDTH-1:0] q_data[$];
   int               q_stamp[$];
   int               cyc      = 0;
   int               wr_idx   = 0;
   int               push_cnt = 0;
   int               pop_cnt  = 0;

   initial begin : compare
      logic             do_push;
      logic             do_pop;
      logic             prev_stall;
      logic [WIDTH-1:0] prev_data;
      logic [WIDTH-1:0] push_data;
      int               push_cyc;
      prev_stall = 1'b0;
      prev_data  = '0;
      push_data  = '0;
      push_cyc   = 0;
      forever begin
         @(negedge clk);
         do_push = 1'b0;
         do_pop  = 1'b0;
         if (!reset) begin
            q_data.delete();
            q_stamp.delete();
            wr_idx     = 0;
            prev_stall = 1'b0;
         end else begin
            int depth;
            bit front_seen;
            depth      = q_data.size();
            front_seen = (depth > 0) && (cyc - q_stamp[0] >= 3);
            check("count", count, 64'(depth));
            check("m_valid", m_valid, 64'(front_seen));
            if (m_valid && depth > 0) check("m_data_order", m_data, q_data[0]);
            if (prev_stall) begin
               check("hold_valid", m_valid, 1);
               check("hold_data", m_data, prev_data);
            end
            if (depth < WORDS)     check("s_ready_room", s_ready, 1);
            if (depth == WORDS + 2) check("s_ready_full", s_ready, 0);
            check("ram_we", ram_we, s_valid && s_ready);
            if (ram_we) begin
               check("ram_waddress", ram_waddress, 64'(wr_idx % WORDS));
               check("ram_din", ram_din, s_data);
            end
            do_push    = s_valid && s_ready;
            do_pop     = m_valid && m_ready;
            push_data  = s_data;
            push_cyc   = cyc;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
         end
         @(posedge clk);
         cyc++;
         if (do_pop && q_data.size() > 0) begin
            void'(q_data.pop_front());
            void'(q_stamp.pop_front());
            pop_cnt++;
         end
         if (do_push) begin
            q_data.push_back(push_data);
            q_stamp.push_back(push_cyc);
            wr_idx++;
            push_cnt++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n       = 0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      while (count != 0 && n < budget) begin
         step();
         @(negedge clk);
         n++;
      end
      check(name, count, 0);
      step();
   endtask

   initial begin : main
      int pb;
      int wb;
      int pushed;
      int spins;
      bit took;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      #1 reset = 1'b0;

      // A request during reset must not reach the RAM.
      s_valid = 1'b1;
      s_data  = 32'hDEAD;
      repeat (2) @(negedge clk);
      check("rst_count", count, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_ram_we", ram_we, 0);
      step();

      // Single word: push 0xA5 in cycle 0, visible in cycle 3, gone in cycle 4.
      reset   = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'hA5;
      m_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("a_s_ready_after_reset", s_ready, 1);
            check("a_ram_we", ram_we, 1);
            check("a_waddr0", ram_waddress, 0);
         end
         check($sformatf("a_m_valid_c%0d", c), m_valid, (c == 3));
         check($sformatf("a_count_c%0d", c), count, (c == 0 || c == 4) ? 0 : 1);
         if (c == 3) check("a_m_data", m_data, 32'hA5);
         step();
         s_valid = 1'b0;
      end

      // Fill: 18 words with no pops reaches full capacity.
      m_ready = 1'b0;
      for (int i = 0; i < 18; i++) begin
         s_valid = 1'b1;
         s_data  = 32'h100 + i;
         @(negedge clk);
         check("b_accept", s_ready, 1);
         step();
      end
      s_data = 32'h999;
      repeat (3) step();
      @(negedge clk);
      check("b_full_s_ready", s_ready, 0);
      check("b_full_count", count, 18);
      check("b_full_ram_count", dut.ram_count_q, 16);
      check("b_head", m_data, 32'h100);
      step();
      drain("b_drain", 60);

      // Streaming: 4096 words, one push and one pop per cycle, pointers wrap 256 times.
      pb      = pop_cnt;
      wb      = push_cnt;
      m_ready = 1'b1;
      for (int i = 0; i < 4096; i++) begin
         s_valid = 1'b1;
         s_data  = i;
         step();
      end
      s_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      check("c_last_valid", m_valid, 1);
      check("c_last_data", m_data, 4095);
      check("c_pops_before_last", pop_cnt - pb, 4095);
      step();
      @(negedge clk);
      check("c_pops", pop_cnt - pb, 4096);
      check("c_pushes", push_cnt - wb, 4096);
      check("c_empty", count, 0);
      step();

      // Random back-pressure: fill-heavy first half, drain-heavy second half.
      pushed = 0;
      spins  = 0;
      s_data = $urandom;
      while (pushed < 10000 && spins < 60000) begin
         s_valid = ($urandom_range(0, 99) < 60);
         m_ready = ($urandom_range(0, 99) < ((pushed < 5000) ? 35 : 75));
         @(negedge clk);
         took = s_valid && s_ready;
         if (took) pushed++;
         step();
         if (took) s_data = $urandom;
         spins++;
      end
      check("d_pushed", pushed, 10000);
      drain("d_drain", 100);

      // Reset with 5 words held and one read in flight.
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1;
         s_data  = 32'h200 + i;
         step();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("e_count_before", count, 5);
      check("e_inflight_before", dut.inflight_q, 1);
      #2 reset = 1'b0;
      #1;
      check("e_rst_m_valid", m_valid, 0);
      check("e_rst_count", count, 0);
      s_valid = 1'b1;
      s_data  = 32'h77;
      @(negedge clk);
      check("e_rst_ram_we", ram_we, 0);
      step();
      reset   = 1'b1;
      s_data  = 32'h11;
      m_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) check("e_waddr0", ram_waddress, 0);
         check($sformatf("e_m_valid_c%0d", c), m_valid, (c == 3));
         if (c == 3) check("e_first_word", m_data, 32'h11);
         step();
         s_valid = 1'b0;
      end
      drain("e_drain", 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end
endmodule
